// File: rtl/spu_mc_pkg.sv
// Shared definitions for the multi-cycle special-purpose unit (spu_mc).
// Contents: operation codes, the trap exception code, the FSM state enum,
// the TLB op enum and small op-class helper functions.
package spu_mc_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_NOP   = 5'd0;
  localparam logic [OP_W-1:0] OP_MFC0  = 5'd1;
  localparam logic [OP_W-1:0] OP_MTC0  = 5'd2;
  localparam logic [OP_W-1:0] OP_TEQ   = 5'd3;
  localparam logic [OP_W-1:0] OP_TNE   = 5'd4;
  localparam logic [OP_W-1:0] OP_TLT   = 5'd5;
  localparam logic [OP_W-1:0] OP_TLTU  = 5'd6;
  localparam logic [OP_W-1:0] OP_TGE   = 5'd7;
  localparam logic [OP_W-1:0] OP_TGEU  = 5'd8;
  localparam logic [OP_W-1:0] OP_TEQI  = 5'd9;
  localparam logic [OP_W-1:0] OP_TNEI  = 5'd10;
  localparam logic [OP_W-1:0] OP_TLTI  = 5'd11;
  localparam logic [OP_W-1:0] OP_TLTIU = 5'd12;
  localparam logic [OP_W-1:0] OP_TGEI  = 5'd13;
  localparam logic [OP_W-1:0] OP_TGEIU = 5'd14;
  localparam logic [OP_W-1:0] OP_ERET  = 5'd15;
  // TLB ops are laid out so that op[1:0] is the tlb_op encoding.
  localparam logic [OP_W-1:0] OP_TLBP  = 5'd16;
  localparam logic [OP_W-1:0] OP_TLBR  = 5'd17;
  localparam logic [OP_W-1:0] OP_TLBWI = 5'd18;
  localparam logic [OP_W-1:0] OP_TLBWR = 5'd19;
  localparam logic [OP_W-1:0] OP_CACHE = 5'd20;

  localparam logic [4:0] EXC_TR = 5'h0D;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StCp0Wait,
    StTlbWait,
    StCacheWait,
    StDrain
  } spu_state_t;

  typedef enum logic [1:0] {
    TlbP  = 2'd0,
    TlbR  = 2'd1,
    TlbWi = 2'd2,
    TlbWr = 2'd3
  } tlb_op_t;

  function automatic logic op_is_trap(input logic [OP_W-1:0] op);
    return (op >= OP_TEQ) && (op <= OP_TGEIU);
  endfunction

  function automatic logic op_is_tlb(input logic [OP_W-1:0] op);
    return (op >= OP_TLBP) && (op <= OP_TLBWR);
  endfunction

endpackage

// File: rtl/spu_trap_cmp.sv
// Trap condition evaluator for the twelve trap forms.
// Ports: op_i (operation code), src1_i / src2_i (operands; src2_i already
// sign-extended for immediate forms), trap_hit_o (condition holds).
// Non-trap ops always give trap_hit_o = 0.
module spu_trap_cmp
  import spu_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              trap_hit_o
);

  logic eq;
  logic slt;
  logic ult;

  assign eq  = (src1_i == src2_i);
  assign slt = ($signed(src1_i) < $signed(src2_i));
  assign ult = (src1_i < src2_i);

  always_comb begin
    trap_hit_o = 1'b0;
    case (op_i)
      OP_TEQ,  OP_TEQI:  trap_hit_o = eq;
      OP_TNE,  OP_TNEI:  trap_hit_o = !eq;
      OP_TLT,  OP_TLTI:  trap_hit_o = slt;
      OP_TGE,  OP_TGEI:  trap_hit_o = !slt;
      OP_TLTU, OP_TLTIU: trap_hit_o = ult;
      OP_TGEU, OP_TGEIU: trap_hit_o = !ult;
      default:           trap_hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/spu_mc.sv
// Multi-cycle special-purpose execution unit.
// Executes MFC0/MTC0, trap forms, ERET, TLB ops and CACHE ops one at a time.
// Ports:
//   clk, reset (async, active low), flush
//   issue_*      : valid/allowin issue handshake plus latched op fields
//   data_paddr   : translated CACHE address, sampled at accept
//   cp0_*        : CP0 read/write strobes, address, data
//   tlb_* / cache_* : req/ack handshakes to MMU and cache
//   commit_*     : valid/ready result handshake from a single output register
module spu_mc
  import spu_mc_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ROB_IDX_W  = 4,
  parameter int unsigned PREG_W     = 6,
  parameter int unsigned CP0_ADDR_W = 8,
  parameter int unsigned PADDR_W    = 32,
  parameter int unsigned CP0_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  issue_valid,
  output logic                  spu_allowin,
  input  logic [OP_W-1:0]       issue_op,
  input  logic [ROB_IDX_W-1:0]  issue_rob_entry,
  input  logic [PREG_W-1:0]     issue_phy_dest,
  input  logic [DATA_W-1:0]     issue_src1,
  input  logic [DATA_W-1:0]     issue_src2,
  input  logic [CP0_ADDR_W-1:0] issue_cp0_addr,
  input  logic [4:0]            issue_cache_op,
  input  logic [PADDR_W-1:0]    data_paddr,
  output logic                  cp0_we,
  output logic                  cp0_re,
  output logic [CP0_ADDR_W-1:0] cp0_addr,
  output logic [DATA_W-1:0]     cp0_wdata,
  input  logic [DATA_W-1:0]     cp0_rdata,
  output logic                  tlb_req,
  output logic [1:0]            tlb_op,
  input  logic                  tlb_ack,
  output logic                  cache_req,
  output logic [4:0]            cache_op,
  output logic [PADDR_W-1:0]    cache_addr,
  input  logic                  cache_ack,
  output logic                  commit_valid,
  input  logic                  commit_ready,
  output logic [ROB_IDX_W-1:0]  commit_rob_entry,
  output logic [3:0]            commit_rf_we,
  output logic [PREG_W-1:0]     commit_phy_dest,
  output logic [DATA_W-1:0]     commit_result,
  output logic                  commit_exc_valid,
  output logic [4:0]            commit_exc_code,
  output logic                  commit_is_eret
);

  localparam int unsigned CntW = (CP0_RD_LAT > 1) ? $clog2(CP0_RD_LAT) : 1;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [ROB_IDX_W-1:0]  rob;
    logic [PREG_W-1:0]     dest;
    logic [DATA_W-1:0]     src1;
    logic [DATA_W-1:0]     src2;
    logic [CP0_ADDR_W-1:0] cp0_addr;
    logic [4:0]            cache_op;
    logic [PADDR_W-1:0]    paddr;
  } stage_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob;
    logic [3:0]           rf_we;
    logic [PREG_W-1:0]    dest;
    logic [DATA_W-1:0]    result;
    logic                 exc_valid;
    logic [4:0]           exc_code;
    logic                 is_eret;
  } out_t;

  spu_state_t      state_q;
  stage_t          stg_q;
  out_t            out_q;
  out_t            out_d;
  logic [CntW-1:0] cnt_q;

  logic    accept;
  logic    trap_hit;
  logic    is_tlb;
  logic    is_cache;
  logic    req_phase;
  logic    ack_now;
  tlb_op_t tlb_sel;

  spu_trap_cmp #(
    .DATA_W(DATA_W)
  ) u_trap_cmp (
    .op_i      (stg_q.op),
    .src1_i    (stg_q.src1),
    .src2_i    (stg_q.src2),
    .trap_hit_o(trap_hit)
  );

  assign spu_allowin = (state_q == StIdle) && !out_q.valid;
  assign accept      = issue_valid && spu_allowin && !flush;

  assign is_tlb   = op_is_tlb(stg_q.op);
  assign is_cache = (stg_q.op == OP_CACHE);

  // The request is already raised in EXEC, so EXEC counts as part of the wait.
  assign req_phase = ((state_q == StExec) && (is_tlb || is_cache)) ||
                     (state_q == StTlbWait) || (state_q == StCacheWait) ||
                     (state_q == StDrain);
  assign ack_now   = (is_tlb && tlb_ack) || (is_cache && cache_ack);

  assign cp0_we    = (state_q == StExec) && (stg_q.op == OP_MTC0) && !flush;
  assign cp0_re    = (state_q == StExec) && (stg_q.op == OP_MFC0) && !flush;
  assign cp0_addr  = stg_q.cp0_addr;
  assign cp0_wdata = stg_q.src2;

  assign tlb_sel    = tlb_op_t'(stg_q.op[1:0]);
  assign tlb_req    = req_phase && is_tlb;
  assign tlb_op     = tlb_req ? tlb_sel : 2'b00;
  assign cache_req  = req_phase && is_cache;
  assign cache_op   = stg_q.cache_op;
  assign cache_addr = stg_q.paddr;

  // Result packet for whatever op is completing this cycle.
  always_comb begin
    out_d           = '0;
    out_d.valid     = 1'b1;
    out_d.rob       = stg_q.rob;
    out_d.dest      = stg_q.dest;
    out_d.is_eret   = (stg_q.op == OP_ERET);
    if (stg_q.op == OP_MFC0) begin
      out_d.rf_we  = 4'hF;
      out_d.result = cp0_rdata;
    end
    if (op_is_trap(stg_q.op) && trap_hit) begin
      out_d.exc_valid = 1'b1;
      out_d.exc_code  = EXC_TR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      stg_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (out_q.valid && commit_ready) begin
        out_q <= '0;
      end

      case (state_q)
        StIdle: begin
          if (accept) begin
            stg_q.op       <= issue_op;
            stg_q.rob      <= issue_rob_entry;
            stg_q.dest     <= issue_phy_dest;
            stg_q.src1     <= issue_src1;
            stg_q.src2     <= issue_src2;
            stg_q.cp0_addr <= issue_cp0_addr;
            stg_q.cache_op <= issue_cache_op;
            stg_q.paddr    <= data_paddr;
            state_q        <= StExec;
          end
        end

        StExec: begin
          if (flush) begin
            // An outstanding TLB/cache request must still be acknowledged.
            if ((is_tlb || is_cache) && !ack_now) begin
              state_q <= StDrain;
            end else begin
              state_q <= StIdle;
              stg_q   <= '0;
            end
          end else if (stg_q.op == OP_MFC0) begin
            cnt_q   <= CntW'(CP0_RD_LAT - 1);
            state_q <= StCp0Wait;
          end else if (is_tlb || is_cache) begin
            if (ack_now) begin
              out_q   <= out_d;
              state_q <= StIdle;
            end else begin
              state_q <= is_tlb ? StTlbWait : StCacheWait;
            end
          end else begin
            out_q   <= out_d;
            state_q <= StIdle;
          end
        end

        StCp0Wait: begin
          if (flush) begin
            state_q <= StIdle;
            stg_q   <= '0;
          end else if (cnt_q == '0) begin
            out_q   <= out_d;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StTlbWait, StCacheWait: begin
          if (ack_now) begin
            if (!flush) begin
              out_q <= out_d;
            end else begin
              stg_q <= '0;
            end
            state_q <= StIdle;
          end else if (flush) begin
            // Stage kept so req/op/addr stay stable until the ack.
            state_q <= StDrain;
          end
        end

        StDrain: begin
          if (ack_now) begin
            state_q <= StIdle;
            stg_q   <= '0;
          end
        end

        default: state_q <= StIdle;
      endcase

      if (flush) begin
        out_q <= '0;
      end
    end
  end

  assign commit_valid     = out_q.valid;
  assign commit_rob_entry = out_q.rob;
  assign commit_rf_we     = out_q.rf_we;
  assign commit_phy_dest  = out_q.dest;
  assign commit_result    = out_q.result;
  assign commit_exc_valid = out_q.exc_valid;
  assign commit_exc_code  = out_q.exc_code;
  assign commit_is_eret   = out_q.is_eret;

endmodule

// File: doc/spu_mc.md
Name: spu_mc

Overview:
- Multi-cycle special-purpose execution unit. Successor to the single-cycle SPU.
- Executes MFC0/MTC0, all twelve trap forms (with real condition evaluation), ERET, the TLBP/TLBR/TLBWI/TLBWR ops and CACHE ops.
- Adds an issue/commit valid-ready handshake, a parametrised CP0 read latency, and request/ack handshakes to the MMU and the cache.
- Sits beside the ALU/LSU in the execute stage. Issue dispatches SPU ops only when they are at the ROB head, so side effects are non-speculative apart from flush.

Parameters:
- DATA_W, 32: operand/result width.
- ROB_IDX_W, 4: ROB entry index width.
- PREG_W, 6: physical register index width.
- CP0_ADDR_W, 8: {sel,rd} CP0 address width.
- PADDR_W, 32: physical address width.
- CP0_RD_LAT, 1: cycles from cp0_re to valid cp0_rdata; must be >=1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush
- issue_valid  in  1  op offered
- spu_allowin  out  1  unit can accept
- issue_op  in  OP_W  decoded operation (OP_*)
- issue_rob_entry  in  ROB_IDX_W  ROB tag
- issue_phy_dest  in  PREG_W  destination physical register
- issue_src1  in  DATA_W  rs value
- issue_src2  in  DATA_W  rt value, or sign-extended immediate for trap-immediate forms
- issue_cp0_addr  in  CP0_ADDR_W  CP0 register address
- issue_cache_op  in  5  CACHE op field
- data_paddr  in  PADDR_W  translated CACHE address, sampled at accept
- cp0_we  out  1  CP0 write strobe
- cp0_re  out  1  CP0 read strobe
- cp0_addr  out  CP0_ADDR_W  CP0 address
- cp0_wdata  out  DATA_W  CP0 write data
- cp0_rdata  in  DATA_W  CP0 read data
- tlb_req  out  1  TLB op request
- tlb_op  out  2  0=P, 1=R, 2=WI, 3=WR
- tlb_ack  in  1  TLB op done
- cache_req  out  1  cache maintenance request
- cache_op  out  5  cache op
- cache_addr  out  PADDR_W  cache address
- cache_ack  in  1  cache op done
- commit_valid  out  1  result valid
- commit_ready  in  1  commit consumes result
- commit_rob_entry  out  ROB_IDX_W  ROB tag
- commit_rf_we  out  4  byte write enables
- commit_phy_dest  out  PREG_W  destination
- commit_result  out  DATA_W  result
- commit_exc_valid  out  1  exception raised
- commit_exc_code  out  5  exception code
- commit_is_eret  out  1  ERET marker

Behaviour:
- States: IDLE, EXEC, CP0_WAIT, TLB_WAIT, CACHE_WAIT, DRAIN. Op fields are latched into a stage register at accept.
- A single output register holds the commit_* fields plus out_valid.
- Reset (reset=0, async): state=IDLE, out_valid=0. All outputs are 0 except spu_allowin=1.
- spu_allowin = (state==IDLE) && !out_valid. Accept = issue_valid && spu_allowin && !flush. If flush is asserted in the accept cycle, flush wins and the op is dropped.
- Cycle t is accept; state=EXEC in t+1. In EXEC:
  - Trap/ERET/MTC0: the output register is loaded at the end of t+1, so commit_valid=1 at t+2.
  - MTC0: cp0_we=1 for exactly the t+1 cycle, with cp0_wdata=src2 and cp0_addr=latched addr.
  - MFC0: cp0_re=1 for one cycle at t+1, then go to CP0_WAIT. A counter loads CP0_RD_LAT-1 and decrements. cp0_rdata is captured when the counter is 0, so commit_valid appears at t+2+CP0_RD_LAT. rf_we=4'hF.
  - TLB*: go to TLB_WAIT. tlb_req stays high from t+1 until the cycle tlb_ack=1 inclusive. The result is loaded that cycle.
  - CACHE: same pattern via CACHE_WAIT/cache_req/cache_ack. cache_addr=latched data_paddr.
- Traps:
  - TEQ/TEQI: src1==src2. TNE/TNEI: src1!=src2.
  - TLT/TLTI, TGE/TGEI: signed compare.
  - TLTU/TLTIU, TGEU/TGEIU: unsigned compare.
  - If the condition holds: exc_valid=1, exc_code=EXC_TR (5'h0D). rf_we=0.
- ERET: is_eret=1, no CP0 access, rf_we=0. Every op other than MFC0 has rf_we=0.
- The output register holds its value while commit_valid && !commit_ready. It clears on the handshake, and the unit returns to IDLE.
- Flush:
  - Clears out_valid and the stage register next edge, and suppresses any cp0_we/cp0_re in that cycle.
  - From EXEC/CP0_WAIT: go to IDLE.
  - From TLB_WAIT/CACHE_WAIT: go to DRAIN. The req stays high until ack, then the unit goes to IDLE with no result. spu_allowin=0 in DRAIN.
  - An ack arriving in the same cycle as flush ends the wait and goes straight to IDLE.
- An ack received outside a wait state is ignored.

Decomposition:
- Shared package (cpu pkg):
  - OP_* codes
  - EXC_TR
  - spu_state_t enum
  - tlb_op_t enum
- One combinational sub-module, spu_trap_cmp (op, src1, src2 -> trap_hit). It is unit-testable in isolation.

Test Plan:
- MTC0 addr 8'h60, src2=32'h1234_0001 -> cp0_we high for exactly one cycle (t+1) with that data; commit_valid at t+2, rf_we=0.
- MFC0 with CP0_RD_LAT=2, cp0_rdata=32'hDEAD_BEEF -> cp0_re at t+1; commit_valid at t+4, result DEAD_BEEF, rf_we=4'hF.
- TLTU src1=32'hFFFF_FFFF, src2=1 -> no exception. TLT with the same operands -> exc_valid=1, exc_code=5'h0D.
- TLBWI with tlb_ack delayed 5 cycles -> tlb_req high for 5 cycles, then commit; spu_allowin=0 throughout.
- CACHE op, flush during CACHE_WAIT, ack 3 cycles later -> cache_req held until ack; no commit_valid; spu_allowin returns to 1 the cycle after ack.
- ERET with commit_ready=0 for 4 cycles -> commit_valid and is_eret held stable for 4 cycles; a second issue is not accepted until the handshake completes.
